// File: rtl/clk_mode_ctrl.sv
// Mode controller and alarm sequencer for the digital clock: button debounce,
// CLOCK/SET/ALARM mode FSM, counter increment enables and ring/snooze control.
//
// Mode FSM                          Alarm FSM
// state   | meaning                 state    | meaning
// M_CLOCK | time runs, inc ignored  A_IDLE   | waiting for a match edge while armed
// M_SET   | time frozen, edit time  A_RING   | buzzer on, ring timer counts ticks
// M_ALARM | time runs, edit alarm   A_SNOOZE | buzzer off, snooze timer counts ticks
module clk_mode_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_pos,
  input  logic       i_btn_inc,
  input  logic       i_btn_alarm,
  input  logic       i_sec_at_max,
  input  logic       i_min_at_max,
  input  logic       i_alarm_match,
  output logic [1:0] o_mode,
  output logic [1:0] o_pos,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hr_inc,
  output logic       o_amin_inc,
  output logic       o_ahr_inc,
  output logic       o_alarm_en,
  output logic       o_buzz_en,
  output logic       o_blink
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int RW = $clog2(RING_SEC) + 1;
  localparam int SW = $clog2(SNOOZE_SEC) + 1;

  typedef enum logic [1:0] {
    M_CLOCK = 2'b00,
    M_SET   = 2'b01,
    M_ALARM = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    A_IDLE   = 2'b00,
    A_RING   = 2'b01,
    A_SNOOZE = 2'b10
  } alarm_t;

  mode_t         mode;
  logic [1:0]    pos;
  alarm_t        astate;
  logic          alarm_en;
  logic          match_q;
  logic [RW-1:0] ring_t;
  logic [SW-1:0] snooze_t;
  logic [PW-1:0] presc;
  logic          tick;

  // Button vector order: 3 alarm, 2 mode, 1 pos, 0 inc
  logic [3:0]    btn_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    lvl;
  logic [3:0]    press;
  logic [DW-1:0] deb_cnt [4];

  assign btn_raw = {i_btn_alarm, i_btn_mode, i_btn_pos, i_btn_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          lvl[i]     <= sync2[i];
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic ev_alarm, ev_mode, ev_pos, ev_inc;
  logic ringing, act_mode, act_pos, act_inc;

  assign ev_alarm = press[3];
  assign ev_mode  = press[2] & ~press[3];
  assign ev_pos   = press[1] & ~|press[3:2];
  assign ev_inc   = press[0] & ~|press[3:1];

  // While ringing, a non-alarm press only means "snooze" and is swallowed here
  assign ringing  = (astate == A_RING);
  assign act_mode = ev_mode & ~ringing;
  assign act_pos  = ev_pos & ~ringing;
  assign act_inc  = ev_inc & ~ringing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + PW'(1);
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= M_CLOCK;
      pos  <= 2'd0;
    end else if (act_mode) begin
      case (mode)
        M_CLOCK: begin
          mode <= M_SET;
          pos  <= 2'd0;
        end
        M_SET: begin
          mode <= M_ALARM;
          pos  <= 2'd1;
        end
        default: mode <= M_CLOCK;
      endcase
    end else if (act_pos) begin
      case (mode)
        M_SET:   pos <= (pos == 2'd2) ? 2'd0 : pos + 2'd1;
        M_ALARM: pos <= (pos == 2'd2) ? 2'd1 : 2'd2;
        default: pos <= pos;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      astate   <= A_IDLE;
      alarm_en <= 1'b0;
      match_q  <= 1'b0;
      ring_t   <= '0;
      snooze_t <= '0;
    end else begin
      match_q <= i_alarm_match;
      case (astate)
        A_IDLE: begin
          if (ev_alarm) begin
            alarm_en <= ~alarm_en;
          end else if (i_alarm_match && !match_q && alarm_en) begin
            astate <= A_RING;
            ring_t <= '0;
          end
        end
        A_RING: begin
          if (ev_alarm) begin
            astate <= A_IDLE;
          end else if (ev_mode || ev_pos || ev_inc) begin
            astate   <= A_SNOOZE;
            snooze_t <= '0;
          end else if (tick) begin
            if (ring_t == RW'(RING_SEC - 1)) astate <= A_IDLE;
            else ring_t <= ring_t + RW'(1);
          end
        end
        A_SNOOZE: begin
          if (ev_alarm) begin
            astate <= A_IDLE;
          end else if (tick) begin
            if (snooze_t == SW'(SNOOZE_SEC - 1)) begin
              astate <= A_RING;
              ring_t <= '0;
            end else begin
              snooze_t <= snooze_t + SW'(1);
            end
          end
        end
        default: astate <= A_IDLE;
      endcase
    end
  end

  logic run_time, set_mode, alarm_mode;

  assign run_time   = (mode != M_SET);
  assign set_mode   = (mode == M_SET);
  assign alarm_mode = (mode == M_ALARM);

  // SET edits one field at a time with no carry into the next field
  assign o_sec_inc  = (run_time & tick) | (set_mode & act_inc & (pos == 2'd0));
  assign o_min_inc  = (run_time & tick & i_sec_at_max) | (set_mode & act_inc & (pos == 2'd1));
  assign o_hr_inc   = (run_time & tick & i_sec_at_max & i_min_at_max)
                    | (set_mode & act_inc & (pos == 2'd2));
  assign o_amin_inc = alarm_mode & act_inc & (pos == 2'd1);
  assign o_ahr_inc  = alarm_mode & act_inc & (pos == 2'd2);

  assign o_mode     = mode;
  assign o_pos      = pos;
  assign o_alarm_en = alarm_en;
  assign o_buzz_en  = ringing;
  assign o_blink    = (mode != M_CLOCK) && (presc < PW'(TICK_DIV / 2));

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// Directed bench for clk_mode_ctrl: every cycle compares the enables (scoreboard
// plus 1 Hz tick model), mode/pos, blink, alarm_en and buzz against expectations.
module tb_clk_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0;  // 3 alarm, 2 mode, 1 pos, 0 inc
  logic       sec_max = 1'b0;
  logic       min_max = 1'b0;
  logic       match = 1'b0;

  logic [1:0] o_mode, o_pos;
  logic       o_sec_inc, o_min_inc, o_hr_inc, o_amin_inc, o_ahr_inc;
  logic       o_alarm_en, o_buzz_en, o_blink;

  clk_mode_ctrl #(
    .TICK_DIV(10), .DEB_CYCLES(4), .RING_SEC(5), .SNOOZE_SEC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_btn_mode(btn[2]), .i_btn_pos(btn[1]), .i_btn_inc(btn[0]), .i_btn_alarm(btn[3]),
    .i_sec_at_max(sec_max), .i_min_at_max(min_max), .i_alarm_match(match),
    .o_mode(o_mode), .o_pos(o_pos),
    .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc), .o_hr_inc(o_hr_inc),
    .o_amin_inc(o_amin_inc), .o_ahr_inc(o_ahr_inc),
    .o_alarm_en(o_alarm_en), .o_buzz_en(o_buzz_en), .o_blink(o_blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] m;  // {sec, min, hr, amin, ahr}
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_ticks = 0;
  int   n_sec = 0, n_min = 0, n_hr = 0, n_amin = 0;
  int   base = 0;
  logic [1:0] exp_mode = 2'b00;
  logic [1:0] exp_pos = 2'b00;
  logic       exp_aen = 1'b0;
  logic       exp_buzz = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [4:0] exp_m;
    logic [4:0] obs_m;
    logic       tick_m;
    exp_t       e;
    tick_m = ((cyc % 10) == 9);
    if (tick_m) n_ticks++;
    exp_m = 5'b0;
    if (tick_m && exp_mode != 2'b01) exp_m = {1'b1, sec_max, sec_max & min_max, 2'b00};
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      exp_m = exp_m | e.m;
    end
    obs_m = {o_sec_inc, o_min_inc, o_hr_inc, o_amin_inc, o_ahr_inc};
    if (o_sec_inc) n_sec++;
    if (o_min_inc) n_min++;
    if (o_hr_inc) n_hr++;
    if (o_amin_inc) n_amin++;
    chk("incs", 8'(obs_m), 8'(exp_m));
    chk("mode", 8'(o_mode), 8'(exp_mode));
    chk("pos", 8'(o_pos), 8'(exp_pos));
    chk("blink", 8'(o_blink), 8'(exp_mode != 2'b00 && (cyc % 10) < 5));
    chk("alarm_en", 8'(o_alarm_en), 8'(exp_aen));
    chk("buzz", 8'(o_buzz_en), 8'(exp_buzz));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  // Raw edge this cycle -> debounced event 6 cycles later
  task automatic press(input logic [3:0] b, input logic [4:0] m);
    exp_t e;
    btn = btn | b;
    if (m != 5'b0) begin
      e.cyc = cyc + 6;
      e.m = m;
      sb.push_back(e);
    end
    repeat (6) step();
  endtask

  task automatic release_all();
    btn = 4'b0;
    repeat (7) step();
  endtask

  initial begin
    #23;
    chk("rst_mode", 8'(o_mode), 8'd0);
    chk("rst_outs", 8'({o_sec_inc, o_min_inc, o_hr_inc, o_amin_inc, o_ahr_inc,
                        o_alarm_en, o_buzz_en, o_blink}), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    check_cycle();

    // free run: ticks at 9, 19, 29; carry to min only at 19
    for (int i = 0; i < 35; i++) begin
      sec_max = (cyc + 1 == 19);
      step();
    end
    sec_max = 1'b0;
    chk("run_sec_cnt", 8'(n_sec), 8'd3);
    chk("run_min_cnt", 8'(n_min), 8'd1);

    // 3-cycle glitch on mode and inc: nothing happens
    btn = 4'b0101;
    repeat (3) step();
    btn = 4'b0000;
    repeat (8) step();

    // CLOCK -> SET
    press(4'b0100, 5'b0);
    exp_mode = 2'b01; exp_pos = 2'd0;
    release_all();

    // SET: pos to 2, inc hits hr only
    press(4'b0010, 5'b0);
    exp_pos = 2'd1;
    release_all();
    press(4'b0010, 5'b0);
    exp_pos = 2'd2;
    release_all();
    n_hr = 0;
    press(4'b0001, 5'b00100);
    release_all();
    chk("set_hr_once", 8'(n_hr), 8'd1);
    n_sec = 0;
    repeat (30) step();
    chk("set_frozen", 8'(n_sec), 8'd0);

    // pos wraps 2 -> 0; inc on sec with no carry even at max
    press(4'b0010, 5'b0);
    exp_pos = 2'd0;
    release_all();
    sec_max = 1'b1; min_max = 1'b1;
    press(4'b0001, 5'b10000);
    release_all();
    sec_max = 1'b0; min_max = 1'b0;

    // SET -> ALARM, inc lands on a tick cycle
    press(4'b0100, 5'b0);
    exp_mode = 2'b10; exp_pos = 2'd1;
    release_all();
    while ((cyc % 10) != 3) step();
    n_amin = 0;
    press(4'b0001, 5'b00010);
    release_all();
    chk("alarm_amin_once", 8'(n_amin), 8'd1);
    n_sec = 0;
    repeat (20) step();
    chk("alarm_sec_ticks", 8'(n_sec), 8'd2);

    // arm, ring, snooze on pos press, re-ring, auto-stop
    press(4'b1000, 5'b0);
    exp_aen = 1'b1;
    release_all();
    match = 1'b1;
    exp_buzz = 1'b1;
    step();
    press(4'b0010, 5'b0);
    exp_buzz = 1'b0;
    base = n_ticks;
    release_all();
    for (int k = 0; k < 40 && (n_ticks - base) < 3; k++) step();
    exp_buzz = 1'b1;
    base = n_ticks;
    for (int k = 0; k < 60 && (n_ticks - base) < 5; k++) step();
    exp_buzz = 1'b0;
    repeat (15) step();

    // alarm + mode together while ringing: alarm wins
    match = 1'b0;
    step();
    match = 1'b1;
    exp_buzz = 1'b1;
    step();
    press(4'b1100, 5'b0);
    exp_buzz = 1'b0;
    release_all();

    // disarm; a new match edge must not ring
    press(4'b1000, 5'b0);
    exp_aen = 1'b0;
    release_all();
    match = 1'b0;
    step();
    match = 1'b1;
    repeat (6) step();
    match = 1'b0;

    // asynchronous reset mid-operation
    while ((cyc % 10) != 2) step();
    rst_n = 1'b0;
    #1;
    chk("arst_mode", 8'(o_mode), 8'd0);
    chk("arst_pos", 8'(o_pos), 8'd0);
    chk("arst_outs", 8'({o_sec_inc, o_min_inc, o_hr_inc, o_amin_inc, o_ahr_inc,
                         o_alarm_en, o_buzz_en, o_blink}), 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    exp_mode = 2'b00; exp_pos = 2'd0; exp_aen = 1'b0; exp_buzz = 1'b0;
    check_cycle();
    n_sec = 0;
    repeat (12) step();
    chk("post_rst_ticks", 8'(n_sec), 8'd1);
    chk("sb_empty", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
